link_out_port: RTL and testbench
================================

Name: link_out_port

Overview:
- Output-port stage directly downstream of the 7-input priority/reduction mux; one instance per outgoing direction (local, ±x, ±y, ±z).
- Captures each valid packet the mux emits into a small FIFO and forwards it onto the inter-node link under credit-based flow control.
- Drives an early-stall signal back toward the mux input side, because the mux cannot be back-pressured once a packet is in its 3-stage pipeline.

Parameters:
- DataWidth, 256: packet width; bit DataWidth-1 is the valid bit.
- FIFODepth, 8: output buffer entries; must be a power of two and at least 4.
- CreditInit, 4: credits held after reset, equal to the downstream receive FIFO depth.
- CreditWidth, 4: width of the credit counter; must hold CreditInit.
- StallHeadroom, 3: free entries reserved for packets already in flight in the mux pipeline.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in  in  DataWidth  packet from the mux.
- send  in  1  packet-valid strobe from the mux (equals in[DataWidth-1]).
- credit_return  in  1  one-cycle pulse; downstream freed one buffer slot.
- out  out  DataWidth  registered packet onto the link.
- out_valid  out  1  registered; out carries a packet this cycle.
- stall_upstream  out  1  mux input side must stop producing.
- occupancy  out  log2(FIFODepth)+1  current FIFO entry count.
- credit_count  out  CreditWidth  credits currently available.
- overflow  out  1  sticky; a packet was dropped.
- credit_err  out  1  sticky; credit returned while already at CreditInit.

Behaviour:
- Reset is asynchronous and active-high. While rst is high:
  - out = 0, out_valid = 0, occupancy = 0, overflow = 0, credit_err = 0.
  - credit_count = CreditInit.
  - Read and write pointers = 0.
- Reset asserted mid-operation discards all buffered packets. Credits return to CreditInit regardless of packets in flight on the link.
- Write rule: wr = send && (not full || rd). A write at full is accepted only if a read happens in the same cycle.
- Drop rule: send && full && !rd drops the packet and sets overflow; overflow stays set until reset.
- send = 0 never writes, including the all-zero bubble the mux emits while a reduction is pending.
- Read rule: rd = !empty && credit_count != 0.
- Output register:
  - On rd: out <= head entry, out_valid <= 1, read pointer advances.
  - Otherwise: out <= 0, out_valid <= 0.
- Latency: a packet written at edge t can appear on out at edge t+1 at the earliest (empty FIFO, credit available). The FIFO preserves arrival order.
- Credit counter update, one per edge:
  - rd only: decrement.
  - credit_return only: increment.
  - rd and credit_return together: unchanged.
  - credit_return at CreditInit with no rd: count held at CreditInit, credit_err set (sticky).
  - credit_count never goes below 0, since rd requires a nonzero count.
- Occupancy update: +1 on wr without rd, -1 on rd without wr, unchanged when both or neither occur.
- Pointer wrap: pointers are log2(FIFODepth) bits wide and wrap modulo FIFODepth. Full and empty are derived from occupancy.
- stall_upstream = (occupancy >= FIFODepth - StallHeadroom). It is combinational from the registered occupancy and therefore asserts the cycle after the triggering write.
- Data bits are never modified: no priority, weight or payload arithmetic happens in this block.

Test Plan:
- Single packet: rst then release, send one packet with in[255] = 1 and in[127:0] = 0x1234, credits = 4.
  - Required: out_valid high exactly 1 cycle later, out equals in bit-for-bit, credit_count goes 4 -> 3.
- Credit exhaustion: send 6 back-to-back packets with no credit_return.
  - Required: exactly 4 emitted on consecutive cycles, then out_valid = 0, occupancy = 2, credit_count = 0.
  - Then pulse credit_return once: exactly one more packet emitted, with in-order payloads.
- Stall and overflow: hold credit_count at 0 and send 9 packets.
  - Required: stall_upstream rises when occupancy reaches 5.
  - Occupancy saturates at 8; the 9th packet is dropped and overflow = 1 and stays 1 until rst.
- Full with simultaneous read/write: FIFO full with 1 credit; in the same cycle send a packet and a read happens.
  - Required: the write is accepted, occupancy stays 8, overflow stays 0.
- Simultaneous credit_return and rd at credit_count = 2: required credit_count stays 2.
  - Then credit_return at credit_count = 4 with the FIFO empty: required credit_count = 4, credit_err = 1.
- Asynchronous reset mid-stream: assert rst between clock edges while occupancy = 5 and credit_count = 1.
  - Required: outputs clear immediately, without waiting for a clock edge.
  - After release: occupancy = 0, credit_count = 4, no stale packet ever appears on out.

Source files
------------

// File: rtl/link_out_port.sv
// Output-port stage behind the 7-input mux: buffers valid packets in a small FIFO and
// forwards them onto the inter-node link under credit-based flow control.
module link_out_port #(
  parameter int DataWidth     = 256,
  parameter int FIFODepth     = 8,
  parameter int CreditInit    = 4,
  parameter int CreditWidth   = 4,
  parameter int StallHeadroom = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DataWidth-1:0]         in,
  input  logic                         send,
  input  logic                         credit_return,
  output logic [DataWidth-1:0]         out,
  output logic                         out_valid,
  output logic                         stall_upstream,
  output logic [$clog2(FIFODepth):0]   occupancy,
  output logic [CreditWidth-1:0]       credit_count,
  output logic                         overflow,
  output logic                         credit_err
);

  localparam int AW = $clog2(FIFODepth);

  typedef logic [AW-1:0]          ptr_t;
  typedef logic [AW:0]            occ_t;
  typedef logic [CreditWidth-1:0] credit_t;

  localparam occ_t    DepthCount = occ_t'(FIFODepth);
  localparam occ_t    StallLevel = occ_t'(FIFODepth - StallHeadroom);
  localparam credit_t CreditFull = credit_t'(CreditInit);

  // Handshake: send is a valid-only strobe with no ready path back to the mux; the mux
  // cannot be stalled mid-pipeline, so stall_upstream warns early while StallHeadroom
  // entries remain free. On the link side out_valid is a valid-only strobe that spends
  // one credit; credit_return gives one back.

  logic [DataWidth-1:0] mem [FIFODepth];
  ptr_t                 wr_ptr;
  ptr_t                 rd_ptr;
  logic                 full;
  logic                 empty;
  logic                 rd;
  logic                 wr;

  always_comb begin
    full           = (occupancy == DepthCount);
    empty          = (occupancy == '0);
    rd             = !empty && (credit_count != '0);
    wr             = send && (!full || rd);
    stall_upstream = (occupancy >= StallLevel);
  end

  // Storage is not reset: occupancy gates every read, so stale words are never forwarded.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd) begin
        rd_ptr    <= rd_ptr + ptr_t'(1);
        out       <= mem[rd_ptr];
        out_valid <= 1'b1;
      end else begin
        out       <= '0;
        out_valid <= 1'b0;
      end
      case ({wr, rd})
        2'b10:   occupancy <= occupancy + occ_t'(1);
        2'b01:   occupancy <= occupancy - occ_t'(1);
        default: occupancy <= occupancy;
      endcase
      if (send && full && !rd) overflow <= 1'b1;
    end
  end

  // A return at the full credit level means the far end returned more than it was sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_count <= CreditFull;
      credit_err   <= 1'b0;
    end else begin
      case ({rd, credit_return})
        2'b10: credit_count <= credit_count - credit_t'(1);
        2'b01: begin
          if (credit_count == CreditFull) credit_err <= 1'b1;
          else credit_count <= credit_count + credit_t'(1);
        end
        default: credit_count <= credit_count;
      endcase
    end
  end

endmodule

// File: tb/tb_link_out_port.sv
// Directed bench for link_out_port: inputs driven and outputs sampled on the falling
// edge, one task per scenario, each with its own hand-computed expectations.
module tb_link_out_port;

  logic         clk;
  logic         rst;
  logic [255:0] in_data;
  logic         send;
  logic         credit_return;
  logic [255:0] out;
  logic         out_valid;
  logic         stall_upstream;
  logic [3:0]   occupancy;
  logic [3:0]   credit_count;
  logic         overflow;
  logic         credit_err;

  int n_cmp;
  int n_fail;
  logic [255:0] exp_q[$];

  link_out_port dut (
    .clk            (clk),
    .rst            (rst),
    .in             (in_data),
    .send           (send),
    .credit_return  (credit_return),
    .out            (out),
    .out_valid      (out_valid),
    .stall_upstream (stall_upstream),
    .occupancy      (occupancy),
    .credit_count   (credit_count),
    .overflow       (overflow),
    .credit_err     (credit_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pkt(input logic [15:0] n);
    logic [255:0] p;
    p            = '0;
    p[255]       = 1'b1;
    p[127:0]     = 128'(n);
    p[191:160]   = 32'hC0DE_0000 | 32'(n);
    return p;
  endfunction

  // driver tasks
  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; send = 1'b0; credit_return = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From an empty, fully credited port: four packets go out, leaving 0 credits, empty FIFO.
  task automatic exhaust_credits();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_data = pkt(16'(16'h0F00 + i)); send = 1'b1;
    end
    @(negedge clk);
    send = 1'b0; in_data = '0;
    for (int i = 0; i < 3; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; send = 1'b0; credit_return = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (out !== '0) begin n_fail++; $display("FAIL reset_out: got %0h want 0", out); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    n_cmp++; if (credit_count !== 4'd4) begin n_fail++; $display("FAIL reset_credit: got %0d want 4", credit_count); end
    n_cmp++; if (overflow !== 1'b0 || credit_err !== 1'b0) begin n_fail++; $display("FAIL reset_sticky: got %0b%0b want 00", overflow, credit_err); end
    n_cmp++; if (stall_upstream !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_upstream); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [255:0] p;
    p = pkt(16'h1234);
    @(negedge clk);
    in_data = p; send = 1'b1;
    @(negedge clk);
    send = 1'b0; in_data = '0;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 4'd1) begin n_fail++; $display("FAIL single_written: got valid=%0b occ=%0d want valid=0 occ=1", out_valid, occupancy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0b want 1", out_valid); end
    n_cmp++; if (out !== p) begin n_fail++; $display("FAIL single_data: got %0h want %0h", out, p); end
    n_cmp++; if (credit_count !== 4'd3 || occupancy !== 4'd0) begin n_fail++; $display("FAIL single_credit: got credit=%0d occ=%0d want credit=3 occ=0", credit_count, occupancy); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0 || out !== '0) begin n_fail++; $display("FAIL single_one_cycle: got valid=%0b out=%0h want 0/0", out_valid, out); end
    credit_return = 1'b1;
    @(negedge clk);
    credit_return = 1'b0;
    n_cmp++; if (credit_count !== 4'd4 || credit_err !== 1'b0) begin n_fail++; $display("FAIL single_refill: got credit=%0d err=%0b want 4/0", credit_count, credit_err); end
  endtask

  task automatic test_credit_exhaustion();
    int emitted, first_c, last_c;
    logic [255:0] e;
    emitted = 0; first_c = -1; last_c = -1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) begin
        emitted++;
        if (first_c < 0) first_c = i;
        last_c = i;
        e = exp_q.pop_front();
        n_cmp++; if (out !== e) begin n_fail++; $display("FAIL exhaust_order: got %0h want %0h", out, e); end
      end
      if (i < 6) begin
        in_data = pkt(16'(16'h0010 + i)); send = 1'b1; exp_q.push_back(pkt(16'(16'h0010 + i)));
      end else begin
        send = 1'b0; in_data = '0;
      end
    end
    n_cmp++; if (emitted != 4 || last_c - first_c != 3) begin n_fail++; $display("FAIL exhaust_count: got %0d in span %0d want 4 in span 3", emitted, last_c - first_c); end
    n_cmp++; if (occupancy !== 4'd2 || credit_count !== 4'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL exhaust_state: got occ=%0d credit=%0d valid=%0b want 2/0/0", occupancy, credit_count, out_valid); end
    credit_return = 1'b1;
    emitted = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      credit_return = 1'b0;
      if (out_valid) begin
        emitted++;
        e = exp_q.pop_front();
        n_cmp++; if (out !== e) begin n_fail++; $display("FAIL exhaust_resume_data: got %0h want %0h", out, e); end
      end
    end
    n_cmp++; if (emitted != 1) begin n_fail++; $display("FAIL exhaust_resume_count: got %0d want 1", emitted); end
    n_cmp++; if (occupancy !== 4'd1 || credit_count !== 4'd0) begin n_fail++; $display("FAIL exhaust_resume_state: got occ=%0d credit=%0d want 1/0", occupancy, credit_count); end
  endtask

  task automatic test_stall_overflow();
    int exp_occ;
    reset_dut();
    exhaust_credits();
    @(negedge clk);
    in_data = pkt(16'h0030); send = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      exp_occ = (i + 1 > 8) ? 8 : i + 1;
      n_cmp++; if (occupancy !== 4'(exp_occ)) begin n_fail++; $display("FAIL stall_occ[%0d]: got %0d want %0d", i, occupancy, exp_occ); end
      n_cmp++; if (stall_upstream !== (exp_occ >= 5)) begin n_fail++; $display("FAIL stall_flag[%0d]: got %0b want %0b", i, stall_upstream, exp_occ >= 5); end
      n_cmp++; if (overflow !== (i == 8)) begin n_fail++; $display("FAIL overflow[%0d]: got %0b want %0b", i, overflow, i == 8); end
      if (i < 8) begin in_data = pkt(16'(16'h0031 + i)); send = 1'b1; end
      else begin send = 1'b0; in_data = '0; end
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_cmp++; if (overflow !== 1'b1 || occupancy !== 4'd8 || out_valid !== 1'b0) begin n_fail++; $display("FAIL overflow_sticky: got ovf=%0b occ=%0d valid=%0b want 1/8/0", overflow, occupancy, out_valid); end
  endtask

  task automatic test_full_rw();
    reset_dut();
    exhaust_credits();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_data = pkt(16'(16'h0040 + i)); send = 1'b1;
    end
    @(negedge clk);
    send = 1'b0; in_data = '0; credit_return = 1'b1;
    n_cmp++; if (occupancy !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_fill: got occ=%0d ovf=%0b want 8/0", occupancy, overflow); end
    @(negedge clk);
    credit_return = 1'b0; in_data = pkt(16'h0099); send = 1'b1;
    n_cmp++; if (credit_count !== 4'd1 || occupancy !== 4'd8) begin n_fail++; $display("FAIL full_credit: got credit=%0d occ=%0d want 1/8", credit_count, occupancy); end
    @(negedge clk);
    send = 1'b0; in_data = '0;
    n_cmp++; if (occupancy !== 4'd8 || overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_accept: got occ=%0d ovf=%0b want 8/0", occupancy, overflow); end
    n_cmp++; if (out_valid !== 1'b1 || out !== pkt(16'h0040) || credit_count !== 4'd0) begin n_fail++; $display("FAIL full_rw_read: got valid=%0b out=%0h credit=%0d want 1/%0h/0", out_valid, out, credit_count, pkt(16'h0040)); end
  endtask

  task automatic test_credit_edges();
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_data = pkt(16'(16'h0050 + i)); send = 1'b1;
    end
    @(negedge clk);
    send = 1'b0; in_data = '0; credit_return = 1'b1;
    n_cmp++; if (credit_count !== 4'd2 || occupancy !== 4'd1) begin n_fail++; $display("FAIL simul_setup: got credit=%0d occ=%0d want 2/1", credit_count, occupancy); end
    @(negedge clk);
    n_cmp++; if (credit_count !== 4'd2) begin n_fail++; $display("FAIL simul_hold: got %0d want 2", credit_count); end
    n_cmp++; if (out_valid !== 1'b1 || out !== pkt(16'h0052)) begin n_fail++; $display("FAIL simul_data: got valid=%0b out=%0h want 1/%0h", out_valid, out, pkt(16'h0052)); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (credit_count !== 4'd4 || credit_err !== 1'b0) begin n_fail++; $display("FAIL refill_full: got credit=%0d err=%0b want 4/0", credit_count, credit_err); end
    @(negedge clk);
    credit_return = 1'b0;
    n_cmp++; if (credit_count !== 4'd4 || credit_err !== 1'b1) begin n_fail++; $display("FAIL credit_err: got credit=%0d err=%0b want 4/1", credit_count, credit_err); end
    @(negedge clk);
    n_cmp++; if (credit_err !== 1'b1) begin n_fail++; $display("FAIL credit_err_sticky: got %0b want 1", credit_err); end
  endtask

  task automatic test_async_reset();
    reset_dut();
    exhaust_credits();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_data = pkt(16'(16'h0060 + i)); send = 1'b1;
      if (i == 4) credit_return = 1'b1;
    end
    @(negedge clk);
    send = 1'b0; in_data = '0; credit_return = 1'b0;
    n_cmp++; if (occupancy !== 4'd5 || credit_count !== 4'd1 || stall_upstream !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got occ=%0d credit=%0d stall=%0b want 5/1/1", occupancy, credit_count, stall_upstream); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (occupancy !== 4'd0 || credit_count !== 4'd4 || stall_upstream !== 1'b0) begin n_fail++; $display("FAIL areset_immediate: got occ=%0d credit=%0d stall=%0b want 0/4/0", occupancy, credit_count, stall_upstream); end
    n_cmp++; if (out_valid !== 1'b0 || out !== '0) begin n_fail++; $display("FAIL areset_out: got valid=%0b out=%0h want 0/0", out_valid, out); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || out !== '0) begin n_fail++; $display("FAIL areset_stale[%0d]: got valid=%0b out=%0h want 0/0", i, out_valid, out); end
    end
    n_cmp++; if (occupancy !== 4'd0 || credit_count !== 4'd4) begin n_fail++; $display("FAIL areset_after: got occ=%0d credit=%0d want 0/4", occupancy, credit_count); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_credit_exhaustion();
    test_stall_overflow();
    test_full_rw();
    test_credit_edges();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
